// File: rtl/svo_tmds_dec_if.sv
`timescale 1ns/1ps
// svo_tmds_dec_if
// Bundle of the signals between an IDES10-style deserializer and one
// TMDS receive decoder channel.
//   din     : raw 10-bit word from the deserializer, bit 0 = first serial bit
//   bitslip : one-cycle request for the deserializer to rotate by one bit
//   locked  : decoder word alignment is established
//   de      : decoded word was a data character
//   ctrl    : decoded control bits {C1,C0}, meaningful while de = 0
//   dout    : decoded pixel byte, meaningful while de = 1
// Modports: slave = decoder side, master = deserializer / consumer side.
interface svo_tmds_dec_if;
   logic [9:0] din;
   logic       bitslip;
   logic       locked;
   logic       de;
   logic [1:0] ctrl;
   logic [7:0] dout;

   modport slave  (input  din, output bitslip, output locked, output de, output ctrl, output dout);
   modport master (output din, input  bitslip, input  locked, input  de, input  ctrl, input  dout);
endinterface

// File: rtl/svo_tmds_dec.sv
`timescale 1ns/1ps
// svo_tmds_dec
// Single-channel TMDS receive decoder. Finds word alignment by steering the
// deserializer bitslip until a run of control tokens is seen, then decodes
// each word into a pixel byte (de = 1) or control bits (de = 0).
// Ports:
//   clk    : pixel clock, all logic on the rising edge
//   resetn : asynchronous active-low reset (released synchronously upstream)
//   bus    : svo_tmds_dec_if.slave (din in; bitslip, locked, de, ctrl, dout out)
// Pipeline: din registered (stage 1), classify/decode registered to the
// outputs (stage 2); two clocks from din to de/ctrl/dout.
// Build option: define SVO_TMDS_DEC_BLANK_EN to force dout to 8'h00 while
// locked and de = 0; otherwise dout holds the last data byte through blanking.
module svo_tmds_dec #(
   parameter int unsigned MIN_CTRL_RUN  = 16,
   parameter int unsigned SEARCH_CYCLES = 2048,
   parameter int unsigned SLIP_WAIT     = 4,
   parameter int unsigned LOCK_TIMEOUT  = 4096
) (
   input  logic          clk,
   input  logic          resetn,
   svo_tmds_dec_if.slave bus
);

   localparam logic [9:0] TOK_C00 = 10'b1101010100;
   localparam logic [9:0] TOK_C01 = 10'b0010101011;
   localparam logic [9:0] TOK_C10 = 10'b0101010100;
   localparam logic [9:0] TOK_C11 = 10'b1010101011;

   localparam int unsigned RUN_W   = $clog2(MIN_CTRL_RUN + 1);
   localparam int unsigned TMR_MAX = (SEARCH_CYCLES > LOCK_TIMEOUT) ?
                                     ((SEARCH_CYCLES > SLIP_WAIT) ? SEARCH_CYCLES : SLIP_WAIT) :
                                     ((LOCK_TIMEOUT  > SLIP_WAIT) ? LOCK_TIMEOUT  : SLIP_WAIT);
   localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

   localparam logic [RUN_W-1:0] RUN_SAT    = RUN_W'(MIN_CTRL_RUN);
   localparam logic [TMR_W-1:0] SEARCH_END = TMR_W'(SEARCH_CYCLES - 1);
   localparam logic [TMR_W-1:0] WAIT_END   = TMR_W'(SLIP_WAIT - 1);
   localparam logic [TMR_W-1:0] LOCK_END   = TMR_W'(LOCK_TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_SLIP   = 2'd1,
      ST_WAIT   = 2'd2,
      ST_LOCKED = 2'd3
   } state_t;

   // Returns {is_token, ctrl}; ctrl is 2'b00 for data characters.
   function automatic logic [2:0] tok_decode(input logic [9:0] w);
      logic [2:0] r;
      case (w)
         TOK_C00: r = {1'b1, 2'b00};
         TOK_C01: r = {1'b1, 2'b01};
         TOK_C10: r = {1'b1, 2'b10};
         TOK_C11: r = {1'b1, 2'b11};
         default: r = {1'b0, 2'b00};
      endcase
      return r;
   endfunction

   // Undo the transmit-side inversion (bit 9) and XOR/XNOR chaining (bit 8).
   function automatic logic [7:0] data_decode(input logic [9:0] w);
      logic [7:0] t;
      logic [7:0] r;
      t    = w[9] ? ~w[7:0] : w[7:0];
      r    = 8'h00;
      r[0] = t[0];
      for (int i = 1; i < 8; i++) begin
         r[i] = w[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
      end
      return r;
   endfunction

   logic [9:0]       din_q,      din_d;
   logic             prev_tok_q, prev_tok_d;
   logic [RUN_W-1:0] run_q,      run_d;
   logic [TMR_W-1:0] timer_q,    timer_d;
   state_t           state_q,    state_d;
   logic             bitslip_q,  bitslip_d;
   logic             locked_q,   locked_d;
   logic             de_q,       de_d;
   logic [1:0]       ctrl_q,     ctrl_d;
   logic [7:0]       dout_q,     dout_d;

   logic             s1_tok;
   logic [1:0]       s1_ctrl;
   logic [7:0]       s1_data;

   // Stage-1 classification of the registered input word.
   always_comb begin
      {s1_tok, s1_ctrl} = tok_decode(din_q);
      s1_data           = data_decode(din_q);
      din_d             = bus.din;
      prev_tok_d        = s1_tok;
   end

   // Saturating count of consecutive tokens; held at zero while the
   // deserializer settles after a slip.
   always_comb begin
      run_d = run_q;
      if ((state_q == ST_SLIP) || (state_q == ST_WAIT)) begin
         run_d = {RUN_W{1'b0}};
      end else if (s1_tok) begin
         run_d = (run_q == RUN_SAT) ? run_q : (run_q + RUN_W'(1));
      end else begin
         run_d = {RUN_W{1'b0}};
      end
   end

   // Alignment FSM: one shared timer serves search, settle and lock watchdog.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      case (state_q)
         ST_SEARCH: begin
            // Reaching the run threshold wins over a simultaneous timeout.
            if (run_d == RUN_SAT) begin
               state_d = ST_LOCKED;
               timer_d = {TMR_W{1'b0}};
            end else if (timer_q == SEARCH_END) begin
               state_d = ST_SLIP;
               timer_d = {TMR_W{1'b0}};
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         ST_SLIP: begin
            state_d = ST_WAIT;
            timer_d = {TMR_W{1'b0}};
         end
         ST_WAIT: begin
            if (timer_q == WAIT_END) begin
               state_d = ST_SEARCH;
               timer_d = {TMR_W{1'b0}};
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         ST_LOCKED: begin
            // Two back-to-back tokens prove blanking is still decoding cleanly.
            if (s1_tok && prev_tok_q) begin
               timer_d = {TMR_W{1'b0}};
            end else if (timer_q == LOCK_END) begin
               state_d = ST_SEARCH;
               timer_d = {TMR_W{1'b0}};
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         default: begin
            state_d = ST_SEARCH;
            timer_d = {TMR_W{1'b0}};
         end
      endcase
   end

   // Stage-2 output decode and gating; bitslip is aligned with the SLIP state.
   always_comb begin
      bitslip_d = (state_d == ST_SLIP);
      locked_d  = (state_q == ST_LOCKED);
      de_d      = 1'b0;
      ctrl_d    = ctrl_q;
      dout_d    = dout_q;
      if (state_q == ST_LOCKED) begin
         if (s1_tok) begin
            de_d   = 1'b0;
            ctrl_d = s1_ctrl;
`ifdef SVO_TMDS_DEC_BLANK_EN
            dout_d = 8'h00;
`else
            dout_d = dout_q;
`endif
         end else begin
            de_d   = 1'b1;
            ctrl_d = ctrl_q;
            dout_d = s1_data;
         end
      end else begin
         de_d   = 1'b0;
         ctrl_d = 2'b00;
         dout_d = 8'h00;
      end
   end

   // All state and output registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         din_q      <= 10'h000;
         prev_tok_q <= 1'b0;
         run_q      <= {RUN_W{1'b0}};
         timer_q    <= {TMR_W{1'b0}};
         state_q    <= ST_SEARCH;
         bitslip_q  <= 1'b0;
         locked_q   <= 1'b0;
         de_q       <= 1'b0;
         ctrl_q     <= 2'b00;
         dout_q     <= 8'h00;
      end else begin
         din_q      <= din_d;
         prev_tok_q <= prev_tok_d;
         run_q      <= run_d;
         timer_q    <= timer_d;
         state_q    <= state_d;
         bitslip_q  <= bitslip_d;
         locked_q   <= locked_d;
         de_q       <= de_d;
         ctrl_q     <= ctrl_d;
         dout_q     <= dout_d;
      end
   end

   assign bus.bitslip = bitslip_q;
   assign bus.locked  = locked_q;
   assign bus.de      = de_q;
   assign bus.ctrl    = ctrl_q;
   assign bus.dout    = dout_q;

endmodule

// File: tb/tb_svo_tmds_dec.sv
`timescale 1ns/1ps
// tb_svo_tmds_dec
// Scoreboard bench for the TMDS receive decoder: expected outputs are queued
// as each word is driven and compared two cycles later.
module tb_svo_tmds_dec;
   localparam logic [9:0] TOK0 = 10'h354;
   localparam logic [9:0] TOK1 = 10'h0AB;
   localparam logic [9:0] TOK2 = 10'h154;
   localparam logic [9:0] TOK3 = 10'h2AB;
   localparam logic [9:0] W_A  = 10'h100;
   localparam logic [9:0] W_B  = 10'h2FF;
   localparam logic [9:0] W_C  = 10'h101;
   localparam logic [9:0] W_D  = 10'h0FF;
   localparam logic [9:0] W_E  = 10'h30F;
   localparam int LINE  = 164;
   localparam int BLANK = 64;

   logic clk    = 1'b0;
   logic resetn = 1'b0;

   svo_tmds_dec_if bus ();
   svo_tmds_dec dut (.clk(clk), .resetn(resetn), .bus(bus));

   always #5 clk = ~clk;

   typedef struct {
      bit         chk;
      bit         lk;
      bit         de;
      logic [1:0] ctrl;
      logic [7:0] dout;
   } exp_t;

   exp_t       sb[$];
   int         n_checks = 0;
   int         n_errors = 0;
   logic [1:0] mdl_ctrl = 2'b00;
   logic [7:0] mdl_dout = 8'h00;
   int         cyc = 0;
   int         slips[$];
   int         rel;
   int         n;
   int         p;

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (resetn && bus.bitslip) slips.push_back(cyc);

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Hand-decoded reference bytes for the data characters used here.
   function automatic logic [8:0] exp_byte(input logic [9:0] w);
      case (w)
         W_A:     return {1'b1, 8'h00};
         W_B:     return {1'b1, 8'hFE};
         W_C:     return {1'b1, 8'h03};
         W_D:     return {1'b1, 8'hFF};
         W_E:     return {1'b1, 8'h10};
         default: return 9'h000;
      endcase
   endfunction

   function automatic logic [2:0] exp_tok(input logic [9:0] w);
      case (w)
         TOK0:    return 3'b100;
         TOK1:    return 3'b101;
         TOK2:    return 3'b110;
         TOK3:    return 3'b111;
         default: return 3'b000;
      endcase
   endfunction

   function automatic logic [9:0] src_word(input int idx);
      int m;
      m = idx % LINE;
      if (m < BLANK) return TOK0;
      else if ((m % 2) == 1) return W_B;
      else return W_A;
   endfunction

   // Deserializer model: word n seen with the serial stream shifted by ph bits.
   function automatic logic [9:0] rx_word(input int idx, input int ph);
      logic [9:0] r;
      logic [9:0] s;
      int         b;
      r = 10'h000;
      for (int j = 0; j < 10; j++) begin
         b    = 10 * idx + ph + j;
         s    = src_word(b / 10);
         r[j] = s[b % 10];
      end
      return r;
   endfunction

   task automatic mdl_push(input logic [9:0] w, input bit chk, input bit lk);
      exp_t       e;
      logic [2:0] tk;
      logic [8:0] by;
      tk    = exp_tok(w);
      by    = exp_byte(w);
      e.chk = chk;
      e.lk  = lk;
      if (!lk) begin
         e.de = 1'b0; e.ctrl = 2'b00; e.dout = 8'h00;
         mdl_ctrl = 2'b00; mdl_dout = 8'h00;
      end else if (tk[2]) begin
         mdl_ctrl = tk[1:0];
`ifdef SVO_TMDS_DEC_BLANK_EN
         mdl_dout = 8'h00;
`endif
         e.de = 1'b0; e.ctrl = mdl_ctrl; e.dout = mdl_dout;
      end else begin
         mdl_dout = by[7:0];
         e.de = 1'b1; e.ctrl = mdl_ctrl; e.dout = mdl_dout;
      end
      sb.push_back(e);
   endtask

   task automatic sb_cycle(input logic [9:0] w_drv, input logic [9:0] w_exp, input bit chk, input bit lk);
      exp_t e;
      if (sb.size() >= 2) begin
         e = sb.pop_front();
         if (e.chk) begin
            check_eq("locked", 32'(bus.locked), 32'(e.lk));
            check_eq("de",     32'(bus.de),     32'(e.de));
            check_eq("ctrl",   32'(bus.ctrl),   32'(e.ctrl));
            check_eq("dout",   32'(bus.dout),   32'(e.dout));
         end
      end
      bus.din = w_drv;
      mdl_push(w_exp, chk, lk);
   endtask

   task automatic step(input logic [9:0] w, input bit chk, input bit lk);
      @(posedge clk); #1;
      sb_cycle(w, w, chk, lk);
   endtask

   initial begin
      bus.din = 10'h000;
      resetn  = 1'b0;

      // Reset held with random input words.
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         bus.din = 10'($urandom_range(0, 1023));
         check_eq("rst_bitslip", 32'(bus.bitslip), 32'd0);
         check_eq("rst_locked",  32'(bus.locked),  32'd0);
         check_eq("rst_de",      32'(bus.de),      32'd0);
         check_eq("rst_ctrl",    32'(bus.ctrl),    32'd0);
         check_eq("rst_dout",    32'(bus.dout),    32'd0);
      end
      bus.din = W_A;
      @(posedge clk); #1;
      resetn = 1'b1;

      // Aligned lock and data decode.
      for (int i = 0; i < 16; i++) step(TOK0, 1'b1, 1'b0);
      step(W_A, 1'b1, 1'b1);
      step(W_B, 1'b1, 1'b1);
      step(W_C, 1'b1, 1'b1);
      step(W_D, 1'b1, 1'b1);
      step(W_E, 1'b1, 1'b1);
      // Control decode.
      step(TOK1, 1'b1, 1'b1);
      step(TOK2, 1'b1, 1'b1);
      step(TOK3, 1'b1, 1'b1);
      step(TOK0, 1'b1, 1'b1);
      // Blanking after data 1011111111.
      step(W_B, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) step(TOK0, 1'b1, 1'b1);

      // Lock loss: no token pairs; the drop lands inside the unchecked window.
      for (int i = 0; i < 4110; i++) step(W_A, (i < 4000) || (i >= 4100), i < 4000);

      // Relock with no slip, then blanking again.
      for (int i = 0; i < 16; i++) step(TOK0, 1'b1, 1'b0);
      step(W_B, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) step(TOK0, 1'b1, 1'b1);
      step(W_C, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) step(W_A, 1'b1, 1'b1);
      check_eq("slips_aligned", 32'(slips.size()), 32'd0);

      // Asynchronous reset while locked with data flowing.
      #2;
      check_eq("pre_rst_de", 32'(bus.de), 32'd1);
      resetn = 1'b0;
      #1;
      check_eq("arst_locked",  32'(bus.locked),  32'd0);
      check_eq("arst_de",      32'(bus.de),      32'd0);
      check_eq("arst_dout",    32'(bus.dout),    32'd0);
      check_eq("arst_bitslip", 32'(bus.bitslip), 32'd0);
      sb.delete();

      // Misaligned stream: received words are shifted 7 bits, three slips realign.
      p = 7;
      n = 0;
      repeat (3) @(posedge clk);
      #1;
      bus.din = rx_word(n, p);
      n++;
      resetn = 1'b1;
      rel = cyc;
      for (int k = 0; (k < 12000) && !bus.locked; k++) begin
         @(posedge clk); #1;
         if (bus.bitslip) p = (p + 1) % 10;
         bus.din = rx_word(n, p);
         n++;
      end
      check_eq("misalign_lock", 32'(bus.locked), 32'd1);
      for (int k = 0; (k < 2 * LINE) && ((n % LINE) != BLANK); k++) begin
         @(posedge clk); #1;
         if (bus.bitslip) p = (p + 1) % 10;
         bus.din = rx_word(n, p);
         n++;
      end
      mdl_ctrl = 2'b00;
      for (int k = 0; k < LINE + 8; k++) begin
         @(posedge clk); #1;
         if (bus.bitslip) p = (p + 1) % 10;
         sb_cycle(rx_word(n, p), src_word(n), 1'b1, 1'b1);
         n++;
      end
      check_eq("slip_count", 32'(slips.size()), 32'd3);
      if (slips.size() > 0) check_eq("slip_first_gap", 32'((slips[0] - rel) >= 2048), 32'd1);
      for (int i = 1; i < slips.size(); i++) begin
         check_eq("slip_gap", 32'((slips[i] - slips[i-1]) >= 2053), 32'd1);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/svo_tmds_dec.md
Name: svo_tmds_dec

Overview:
- Single-channel TMDS receive decoder; the receive-side counterpart of the per-channel TMDS encoder plus OSER10 serializer on the transmit path.
- Takes 10-bit parallel words from an IDES10-style deserializer in the pixel clock domain.
- Finds word alignment by steering the deserializer's bitslip input, then decodes each word to data, control or DE.
- Three instances plus a sync/timing recovery block form the HDMI/DVI input path.

Parameters:
- MIN_CTRL_RUN, 16, consecutive control tokens required to declare lock (must be < shortest blanking, 160 at 640x480).
- SEARCH_CYCLES, 2048, cycles in SEARCH without reaching MIN_CTRL_RUN before a bitslip (must exceed one line, 800 at 640x480).
- SLIP_WAIT, 4, cycles ignored after a bitslip pulse while the deserializer settles.
- LOCK_TIMEOUT, 4096, cycles in LOCKED without two consecutive control tokens before lock is dropped.

Ports:
- clk  input  1  pixel clock; all logic on its rising edge.
- resetn  input  1  asynchronous active-low reset.
- din  input  10  raw word from deserializer; bit 0 = first serial bit.
- bitslip  output  1  one-cycle pulse; deserializer rotates by one bit.
- locked  output  1  alignment FSM in LOCKED.
- de  output  1  data enable (decoded word was a data character).
- ctrl  output  2  decoded control bits {C1,C0}; valid when de=0.
- dout  output  8  decoded pixel byte; valid when de=1.

Behaviour:
- Reset (async assert, sync release): bitslip=0, locked=0, de=0, ctrl=2'b00, dout=8'h00, FSM=SEARCH, all counters 0.
- Pipeline: din registered (stage 1); classify/decode registered to outputs (stage 2). Latency is 2 clk from din to de/ctrl/dout. No backpressure; one word per cycle.
- Control tokens (din[9:0]): 1101010100 gives ctrl 00; 0010101011 gives 01; 0101010100 gives 10; 1010101011 gives 11. Any other word is a data character.
- Data decode:
  - t = din[9] ? ~din[7:0] : din[7:0].
  - dout[0] = t[0].
  - dout[i] = din[8] ? t[i]^t[i-1] : ~(t[i]^t[i-1]), for i = 1..7.
- Output gating:
  - While locked=1: token gives de=0 and ctrl=decoded; data gives de=1 and dout=decoded. ctrl holds its last value during data.
  - While locked=0: de=0, ctrl=00, dout=00.
- run counter:
  - Increments on each stage-1 token; clears on a data word.
  - Saturates at MIN_CTRL_RUN.
- FSM states:
  - SEARCH: timer increments each cycle. run reaching MIN_CTRL_RUN goes to LOCKED, timer cleared. Timer reaching SEARCH_CYCLES-1 goes to SLIP.
  - SLIP: bitslip=1 for exactly this cycle, then WAIT.
  - WAIT: ignores din; counts SLIP_WAIT cycles, then SEARCH with run and timer cleared.
  - LOCKED: timer clears on any cycle where the current and previous stage-1 words are both tokens; otherwise increments. Timer reaching LOCK_TIMEOUT-1 goes to SEARCH.
- locked is a registered decode of the FSM state. It rises the cycle after entering LOCKED and falls the cycle after leaving it.
- bitslip is never asserted in consecutive cycles. There are at least SLIP_WAIT+1 cycles between pulses. Slipping wraps indefinitely, so 10 slips returns to the original phase.
- Simultaneous events in SEARCH: if run reaches threshold on the same cycle the timer expires, LOCKED wins and no slip is issued.
- Reset mid-operation: immediate return to reset values; any bitslip pulse in progress is truncated.

Optional Feature:
- Macro SVO_TMDS_DEC_BLANK_EN.
- Defined: while locked=1 and de=0, dout forced to 8'h00.
- Undefined: dout holds the last decoded data byte through blanking.
- de, ctrl, locked and bitslip behaviour are identical in both builds.

Test Plan:
- Reset: hold resetn=0 with random din → bitslip=0, locked=0, de=0, ctrl=00, dout=00. Release → same until lock.
- Aligned lock: 16 words 1101010100, then 0100000000, then 1011111111 → locked=1 after the 16th token. First data word gives de=1, dout=8'h00 two cycles after its input; second gives dout=8'hFE.
- Control decode: locked stream of 0010101011, 0101010100, 1010101011 → ctrl=01, 10, 11 with de=0, each 2 cycles after input.
- Misalignment: bench model rotates the serial stream by 3 bits and applies bitslip → exactly 3 bitslip pulses, each ≥5 cycles apart and ≥2048 cycles after the previous search start. locked=1 afterwards and decoded data is correct.
- Lock loss: after lock, 4096 data words 0100000000 with no token pairs → locked falls at the 4096th cycle, de=0 thereafter, FSM in SEARCH. A second run of 16 tokens relocks with no bitslip.
- Macro and reset: during blanking after data 1011111111, dout=8'hFE without SVO_TMDS_DEC_BLANK_EN and 8'h00 with it. Assert resetn=0 in LOCKED → locked and de fall asynchronously.
